// File: rtl/reg_bcd_display.sv
// rtl/reg_bcd_display.sv - 16-bit binary to 5-digit BCD (double-dabble) with seven-segment outputs
// Optional macro LEADING_ZERO_BLANK_EN blanks leading-zero digits on HEX1..HEX4.
module reg_bcd_display #(
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic        clk_i,
    input  logic        resetn_i,
    input  logic        start_i,
    input  logic [15:0] value_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [19:0] bcd_o,
    output logic [6:0]  hex0_o,
    output logic [6:0]  hex1_o,
    output logic [6:0]  hex2_o,
    output logic [6:0]  hex3_o,
    output logic [6:0]  hex4_o
);

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

    state_t          state_q, state_d;
    logic [15:0]     sr_q, sr_d;
    logic [19:0]     scratch_q, scratch_d;
    logic [19:0]     adj;
    logic [3:0]      cnt_q, cnt_d;
    logic [19:0]     bcd_q, bcd_d;
    logic            done_q, done_d;
    logic            busy_q;
    logic [4:0][6:0] hex_q, hex_d;

    // Active-low gfedcba pattern; non-decimal codes are dark.
    function automatic logic [6:0] seg_al(input logic [3:0] d);
        case (d)
            4'd0:    seg_al = 7'b1000000;
            4'd1:    seg_al = 7'b1111001;
            4'd2:    seg_al = 7'b0100100;
            4'd3:    seg_al = 7'b0110000;
            4'd4:    seg_al = 7'b0011001;
            4'd5:    seg_al = 7'b0010010;
            4'd6:    seg_al = 7'b0000010;
            4'd7:    seg_al = 7'b1111000;
            4'd8:    seg_al = 7'b0000000;
            4'd9:    seg_al = 7'b0010000;
            default: seg_al = 7'b1111111;
        endcase
    endfunction

    // Walk from the top digit down so "this and all higher digits are zero" is a running AND.
    function automatic logic [4:0][6:0] encode(input logic [19:0] bcd);
        logic            hz;
        logic [6:0]      al;
        logic [4:0][6:0] r;
        hz = 1'b1;
        r  = '0;
        for (int n = 4; n >= 0; n--) begin
            hz = hz & (bcd[n*4 +: 4] == 4'd0);
            al = (BLANK_EN && hz && (n != 0)) ? 7'b1111111 : seg_al(bcd[n*4 +: 4]);
            r[n] = SEG_ACTIVE_LOW ? al : ~al;
        end
        return r;
    endfunction

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        hex_d     = hex_q;
        done_d    = 1'b0;
        adj       = scratch_q;
        for (int i = 0; i < 5; i++) begin
            if (adj[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = adj[i*4 +: 4] + 4'd3;
        end
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    sr_d      = value_i;
                    scratch_d = '0;
                    cnt_d     = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                scratch_d = {adj[18:0], sr_q[15]};
                sr_d      = {sr_q[14:0], 1'b0};
                cnt_d     = cnt_q + 4'd1;
                if (cnt_q == 4'd15) state_d = LOAD;
            end
            LOAD: begin
                bcd_d   = scratch_q;
                hex_d   = encode(scratch_q);
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            bcd_q     <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            hex_q     <= encode(20'h0);
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
            done_q    <= done_d;
            busy_q    <= (state_d != IDLE);
            hex_q     <= hex_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign bcd_o  = bcd_q;
    assign hex0_o = hex_q[0];
    assign hex1_o = hex_q[1];
    assign hex2_o = hex_q[2];
    assign hex3_o = hex_q[3];
    assign hex4_o = hex_q[4];

endmodule

// File: doc/reg_bcd_display.md
REG_BCD_DISPLAY -- requirements
Module: reg_bcd_display

Interface
REQ-001 Parameter SEG_ACTIVE_LOW, default 1, sets segment polarity: 1 means a lit segment is driven 0; 0 inverts every HEXn bit.
REQ-002 Clock  input  1  single clock; all state updates on its rising edge.
REQ-003 Resetn  input  1  asynchronous, active-low reset.
REQ-004 Start  input  1  conversion request; level-sampled only in IDLE.
REQ-005 Value  input  16  unsigned binary register value (processor R0..R7); sampled on the accepting edge.
REQ-006 Busy  output  1  high while a conversion is in progress.
REQ-007 Done  output  1  one-cycle pulse when new digits are presented.
REQ-008 Bcd  output  20  five BCD digits; [3:0]=units ... [19:16]=ten-thousands.
REQ-009 HEX0..HEX4  output  7 each  seven-segment patterns; HEX0=units, HEX4=ten-thousands; bit0=a ... bit6=g.

Function
REQ-010 The FSM SHALL have three states: IDLE, SHIFT, LOAD.
REQ-011 IDLE with Start=1 at an edge SHALL: capture Value into a 16-bit shift register; clear a 20-bit scratch BCD register; clear a 4-bit step counter; go to SHIFT.
REQ-012 Each SHIFT edge SHALL first add 3 to every scratch digit >=5, then left-shift {scratch, shift register} by one bit.
- counter increments on every SHIFT edge
- on the edge where counter==15, go to LOAD (exactly 16 shifts)
REQ-013 The LOAD edge SHALL:
- copy scratch into Bcd
- update HEX0..HEX4 from the new digits
- assert Done for exactly one cycle
- return to IDLE
REQ-014 Latency SHALL be fixed: counting the Start-accepting edge as edge 1, Done and new outputs appear after edge 18.
REQ-015 Busy SHALL be high in SHIFT and LOAD and low in IDLE, registered with the state.
REQ-016 Start in SHIFT or LOAD SHALL be ignored, and Value changes after the accepting edge SHALL NOT affect the result.
REQ-017 Start held high SHALL start a new conversion on the first edge in IDLE after LOAD, so back-to-back conversions repeat every 18 cycles.
REQ-018 Bcd and HEX0..HEX4 SHALL hold their last values between LOAD states.
REQ-019 Segment encoding (active-low, gfedcba):
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
- 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
REQ-020 A scratch digit outside 0-9 SHALL be unreachable, and the decoder SHALL map it to all-segments-off.
REQ-021 Full-scale 65535 SHALL convert correctly, with no overflow past five digits.

Reset
REQ-022 Resetn low SHALL immediately force: state IDLE, Busy 0, Done 0, Bcd 0, counter 0, scratch 0, shift register 0.
REQ-023 Resetn low SHALL set HEX0 to the "0" pattern, and HEX1..HEX4 per REQ-025/REQ-026.
REQ-024 Reset asserted mid-conversion SHALL abort the conversion, with no Done pulse; after release the block waits in IDLE for Start.

Configuration
REQ-025 With macro LEADING_ZERO_BLANK_EN defined:
- HEXn for n>=1 SHALL be all-off (1111111 active-low) when digit n and all higher digits are 0
- HEX0 is never blanked
- blanking is recomputed at LOAD and applies to reset values
REQ-026 Without LEADING_ZERO_BLANK_EN, every HEXn SHALL display its digit, including leading zeros; Bcd is unaffected either way.

Verification
REQ-027 Reset, then Value=0, Start pulse -> Done after edge 18; Bcd=0x00000; HEX0=1000000; HEX1..4 blank (macro) or 1000000 (no macro).
REQ-028 Value=65535, Start pulse -> Bcd=0x65535; HEX4..HEX0 = 6,5,5,3,5 patterns; Busy high for exactly 17 cycles.
REQ-029 Value=1234, Start pulse; Value changed to 9999 and Start pulsed again at edge 5 -> single Done; Bcd=0x01234; no second conversion.
REQ-030 Start held high, Value=10 -> Done pulses 18 cycles apart; Bcd=0x00010; with macro, HEX2..HEX4 blank and HEX1=1111001.
REQ-031 Resetn low at edge 9 of a conversion of 500 -> Busy/Done drop immediately; outputs at reset values; no Done after release until a new Start.
REQ-032 SEG_ACTIVE_LOW=0, Value=8 -> HEX0=1111111, the bitwise inverse of the active-low "8" pattern.
